rvfi_retire_serializer: RTL and testbench

Serializes the NRET-wide RVFI retirement bus of the core into a single-lane, in-order record stream with valid/ready backpressure. It sits between the flattened per-slot RVFI outputs and any single-port consumer, such as the trace logger or the contract-checker. It buffers retirement bursts in a small FIFO, detects overflow and checks `order` continuity. The core cannot be stalled, so loss is flagged rather than prevented.

---
 rtl/rvfi_retire_serializer.sv | 138 +++++++++++++
 tb/tb_rvfi_retire_serializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_retire_serializer.sv
// rvfi_retire_serializer
// Folds the NRET-wide RVFI retirement bus into one in-order record stream with
// valid/ready backpressure. Retire groups land in a small FIFO as a unit: a
// group that does not fit is dropped whole and counted, because the core
// cannot be stalled. A checker on the output side watches `order` continuity.
// DEPTH must be a power of two and at least max(NRET, 2).

module rvfi_retire_serializer #(
    parameter int NRET  = 2,
    parameter int REC_W = 256,
    parameter int DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NRET-1:0]       valid_i,
    input  logic [NRET*64-1:0]    order_i,
    input  logic [NRET*REC_W-1:0] rec_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [63:0]           out_order_o,
    output logic [REC_W-1:0]      out_rec_o,
    output logic                  overflow_o,
    output logic                  order_err_o,
    output logic [15:0]           drop_cnt_o,
    output logic [63:0]           emit_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Storage; write ports below, read is a plain index by rd_ptr_reg.
    logic [63:0]      order_mem [DEPTH];
    logic [REC_W-1:0] rec_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [63:0]      exp_reg;
    logic             have_exp_reg;
    logic             overflow_reg;
    logic             order_err_reg;
    logic [15:0]      drop_cnt_reg;
    logic [63:0]      emit_cnt_reg;

    // slot_off[k] = number of valid slots below k, i.e. the compacted
    // position of slot k inside its group; slot_off[NRET] is the group size.
    logic [CNT_W-1:0] slot_off   [NRET+1];
    logic [PTR_W-1:0] slot_addr  [NRET];
    logic [63:0]      slot_order [NRET];
    logic [REC_W-1:0] slot_rec   [NRET];

    logic [CNT_W-1:0] grp_n;
    logic [CNT_W-1:0] free_slots;
    logic             accept;
    logic             reject;
    logic             pop;
    logic [16:0]      drop_sum;

    assign slot_off[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < NRET; gi++) begin : g_slot
            assign slot_off[gi+1]  = slot_off[gi] + CNT_W'(valid_i[gi]);
            assign slot_addr[gi]   = wr_ptr_reg + PTR_W'(slot_off[gi]);
            assign slot_order[gi]  = order_i[64*gi +: 64];
            assign slot_rec[gi]    = rec_i[REC_W*gi +: REC_W];
        end
    endgenerate

    assign grp_n      = slot_off[NRET];
    // Space is judged on start-of-cycle occupancy only; a same-cycle pop
    // does not lend its slot to the incoming group.
    assign free_slots = DEPTH_C - count_reg;
    assign accept     = (grp_n != '0) && (grp_n <= free_slots);
    assign reject     = (grp_n != '0) && (grp_n > free_slots);
    assign pop        = out_valid_o && out_ready_i;
    assign count_next = count_reg + (accept ? grp_n : '0) - CNT_W'(pop);
    assign drop_sum   = {1'b0, drop_cnt_reg} + 17'(grp_n);

    assign out_valid_o = (count_reg != '0);
    assign out_order_o = order_mem[rd_ptr_reg];
    assign out_rec_o   = rec_mem[rd_ptr_reg];
    assign overflow_o  = overflow_reg;
    assign order_err_o = order_err_reg;
    assign drop_cnt_o  = drop_cnt_reg;
    assign emit_cnt_o  = emit_cnt_reg;

    // Write every valid slot of an accepted group at its compacted address.
    always_ff @(posedge clk_i) begin
        if (!rst_i && accept) begin
            for (int k = 0; k < NRET; k++) begin
                if (valid_i[k]) begin
                    order_mem[slot_addr[k]] <= slot_order[k];
                    rec_mem[slot_addr[k]]   <= slot_rec[k];
                end
            end
        end
    end

    // Pointers, occupancy, loss accounting and the order-continuity checker.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            exp_reg       <= '0;
            have_exp_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            order_err_reg <= 1'b0;
            drop_cnt_reg  <= '0;
            emit_cnt_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(grp_n);
            end
            if (reject) begin
                overflow_reg <= 1'b1;
                drop_cnt_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
            if (pop) begin
                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                emit_cnt_reg <= emit_cnt_reg + 64'd1;
                // Always resynchronise to the popped order so one gap
                // reports once rather than on every later record.
                if (have_exp_reg && (out_order_o != exp_reg)) begin
                    order_err_reg <= 1'b1;
                end
                exp_reg      <= out_order_o + 64'd1;
                have_exp_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// Bench for rvfi_retire_serializer: directed retire groups feed a scoreboard
// queue of expected orders; an independent monitor pops and compares every
// record the DUT hands over.

module tb_rvfi_retire_serializer;

    localparam int NRET  = 2;
    localparam int REC_W = 256;
    localparam int DEPTH = 8;

    logic                  clk = 1'b0;
    logic                  rst_i;
    logic [NRET-1:0]       valid_i;
    logic [NRET*64-1:0]    order_i;
    logic [NRET*REC_W-1:0] rec_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [63:0]           out_order_o;
    logic [REC_W-1:0]      out_rec_o;
    logic                  overflow_o;
    logic                  order_err_o;
    logic [15:0]           drop_cnt_o;
    logic [63:0]           emit_cnt_o;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb [$];

    rvfi_retire_serializer #(.NRET(NRET), .REC_W(REC_W), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .order_i     (order_i),
        .rec_i       (rec_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_order_o (out_order_o),
        .out_rec_o   (out_rec_o),
        .overflow_o  (overflow_o),
        .order_err_o (order_err_o),
        .drop_cnt_o  (drop_cnt_o),
        .emit_cnt_o  (emit_cnt_o)
    );

    always #5 clk = ~clk;

    // Payload derived from order so the record lanes are checked too.
    function automatic logic [REC_W-1:0] mk_rec(input logic [63:0] o);
        return {o ^ 64'hA5A5_5A5A_0F0F_F0F0, ~o, o + 64'd7, o};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Monitor: sample mid-cycle; a pop happens at the next rising edge.
    always @(negedge clk) begin
        if (!rst_i && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got order %0d expected no record", out_order_o);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                if (out_order_o !== e || out_rec_o !== mk_rec(e)) begin
                    bad++;
                    $display("FAIL pop_record: got order %0d rec %h expected order %0d", out_order_o, out_rec_o, e);
                end else begin
                    $display("pop  order=%0d", out_order_o);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one retire group for one cycle; acc says whether it should fit.
    task automatic retire(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1, input bit acc);
        valid_i = v;
        order_i = {o1, o0};
        rec_i   = {mk_rec(o1), mk_rec(o0)};
        if (acc) begin
            if (v[0]) sb.push_back(o0);
            if (v[1]) sb.push_back(o1);
        end
        $display("push v=%b o0=%0d o1=%0d acc=%0d", v, o0, o1, acc);
        tick();
        valid_i = '0;
    endtask

    // One-cycle reset, optionally with a retire group presented that must be ignored.
    task automatic do_reset(input logic [1:0] v);
        out_ready_i = 1'b0;
        rst_i   = 1'b1;
        valid_i = v;
        order_i = {64'd78, 64'd77};
        rec_i   = {mk_rec(64'd78), mk_rec(64'd77)};
        tick();
        rst_i   = 1'b0;
        valid_i = '0;
        sb.delete();
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_overflow",  64'(overflow_o),  64'd0);
        check("rst_order_err", 64'(order_err_o), 64'd0);
        check("rst_drop_cnt",  64'(drop_cnt_o),  64'd0);
        check("rst_emit_cnt",  emit_cnt_o,       64'd0);
    endtask

    task automatic drain();
        out_ready_i = 1'b1;
        for (int i = 0; i < 64 && (sb.size() != 0 || out_valid_o); i++) tick();
        check("drain_empty", 64'(sb.size() == 0 && !out_valid_o), 64'd1);
    endtask

    initial begin
        rst_i = 1'b1; valid_i = '0; order_i = '0; rec_i = '0; out_ready_i = 1'b0;
        repeat (3) tick();
        do_reset(2'b00);

        // Basic in-order flow.
        out_ready_i = 1'b1;
        retire(2'b11, 64'd10, 64'd11, 1'b1);
        check("basic_head_valid", 64'(out_valid_o), 64'd1);
        check("basic_head_order", out_order_o, 64'd10);
        retire(2'b10, 64'd0, 64'd12, 1'b1);
        check("basic_second", out_order_o, 64'd11);
        tick();
        check("basic_third", out_order_o, 64'd12);
        tick();
        check("basic_emit", emit_cnt_o, 64'd3);
        check("basic_err", 64'(order_err_o), 64'd0);
        check("basic_idle", 64'(out_valid_o), 64'd0);

        // Backpressure hold and overflow.
        do_reset(2'b00);
        for (int g = 0; g < 4; g++) begin
            retire(2'b11, 64'(2*g), 64'(2*g+1), 1'b1);
            check("hold_order", out_order_o, 64'd0);
            check("hold_valid", 64'(out_valid_o), 64'd1);
        end
        retire(2'b11, 64'd8, 64'd9, 1'b0);
        check("ovf_flag", 64'(overflow_o), 64'd1);
        check("ovf_drop", 64'(drop_cnt_o), 64'd2);
        check("ovf_head", out_order_o, 64'd0);

        // No pop credit: full FIFO, pop and push in the same cycle.
        out_ready_i = 1'b1;
        retire(2'b01, 64'd8, 64'd0, 1'b0);
        check("credit_drop", 64'(drop_cnt_o), 64'd3);
        check("credit_head", out_order_o, 64'd1);
        retire(2'b01, 64'd9, 64'd0, 1'b1);
        check("credit_drop_same", 64'(drop_cnt_o), 64'd3);
        drain();
        check("credit_err", 64'(order_err_o), 64'd1);
        check("credit_emit", emit_cnt_o, 64'd9);

        // Order check: establish exp=5, then a gap.
        do_reset(2'b00);
        out_ready_i = 1'b1;
        retire(2'b01, 64'd4, 64'd0, 1'b1);
        tick();
        check("ord_no_err", 64'(order_err_o), 64'd0);
        retire(2'b01, 64'd7, 64'd0, 1'b1);
        check("ord_before_pop", 64'(order_err_o), 64'd0);
        tick();
        check("ord_gap_err", 64'(order_err_o), 64'd1);
        retire(2'b01, 64'd8, 64'd0, 1'b1);
        tick();
        check("ord_err_sticky", 64'(order_err_o), 64'd1);
        check("ord_emit", emit_cnt_o, 64'd3);
        check("ord_no_ovf", 64'(overflow_o), 64'd0);

        // Wrap-around stream of 100 orders with random backpressure.
        do_reset(2'b00);
        begin
            logic [63:0] nxt;
            int sent;
            int g;
            nxt = 64'd1000;
            sent = 0;
            for (int cyc = 0; cyc < 2000 && sent < 100; cyc++) begin
                out_ready_i = 1'($urandom_range(0, 1));
                if (sb.size() <= DEPTH - 2) begin
                    g = $urandom_range(1, 3);
                    if (g == 3 && sent == 99) g = 1;
                    if (g == 3) begin
                        retire(2'b11, nxt, nxt + 64'd1, 1'b1);
                        nxt += 64'd2; sent += 2;
                    end else if (g == 1) begin
                        retire(2'b01, nxt, 64'd0, 1'b1);
                        nxt += 64'd1; sent += 1;
                    end else begin
                        retire(2'b10, 64'd0, nxt, 1'b1);
                        nxt += 64'd1; sent += 1;
                    end
                end else begin
                    tick();
                end
            end
            check("wrap_sent", 64'(sent), 64'd100);
        end
        drain();
        check("wrap_emit", emit_cnt_o, 64'd100);
        check("wrap_ovf", 64'(overflow_o), 64'd0);
        check("wrap_err", 64'(order_err_o), 64'd0);

        // Mid-stream reset with 5 entries buffered and inputs in the reset cycle.
        out_ready_i = 1'b0;
        retire(2'b11, 64'd0, 64'd1, 1'b1);
        retire(2'b11, 64'd2, 64'd3, 1'b1);
        retire(2'b01, 64'd4, 64'd0, 1'b1);
        check("mid_buffered", 64'(out_valid_o), 64'd1);
        do_reset(2'b11);
        tick();
        check("mid_still_empty", 64'(out_valid_o), 64'd0);
        out_ready_i = 1'b1;
        retire(2'b01, 64'd50, 64'd0, 1'b1);
        tick();
        check("mid_first_pop_err", 64'(order_err_o), 64'd0);
        check("mid_emit", emit_cnt_o, 64'd1);
        check("mid_sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
